// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate extender pipeline stage.
package imm_pkg;

    // Default widths used by the core's immediate path.
    localparam int IMM_IN_W  = 16;
    localparam int IMM_OUT_W = 32;
    localparam int IMM_SHAMT = 2;

    // Extension mode carried alongside each immediate from decode.
    typedef logic [1:0] imm_mode_t;

    localparam imm_mode_t MODE_ZERO   = 2'b00;
    localparam imm_mode_t MODE_SIGN   = 2'b01;
    localparam imm_mode_t MODE_UPPER  = 2'b10;
    localparam imm_mode_t MODE_BRANCH = 2'b11;

    // Occupancy state, encoded directly as {skid_valid, out_valid}.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } pipe_state_t;

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extension: zero, sign, upper-load and
// scaled branch offset. Results are truncated to OUT_W.
module imm_ext_core
    import imm_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W,
    parameter int SHAMT = IMM_SHAMT
) (
    input  logic [IN_W-1:0]  i_imm,
    input  imm_mode_t        i_mode,
    output logic [OUT_W-1:0] o_data
);

    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_upper;
    logic [OUT_W-1:0] w_branch;

    // Casts rather than explicit replications keep OUT_W == IN_W legal.
    assign w_zext   = OUT_W'(i_imm);
    assign w_sext   = OUT_W'($signed(i_imm));
    assign w_upper  = w_zext << (OUT_W - IN_W);
    assign w_branch = w_sext << SHAMT;

    // Select the extension for the requested mode.
    always_comb begin
        o_data = w_zext;
        case (i_mode)
            MODE_ZERO:   o_data = w_zext;
            MODE_SIGN:   o_data = w_sext;
            MODE_UPPER:  o_data = w_upper;
            MODE_BRANCH: o_data = w_branch;
            default:     o_data = w_zext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with valid/ready on both sides. A one-word
// skid register behind the output register gives full throughput while
// in_ready comes straight from a flop.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_EMPTY | nothing held; out_valid=0, in_ready=1
// ST_ONE   | out_data holds a word; skid empty, in_ready=1
// ST_FULL  | out_data and skid both hold words; in_ready=0
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W,
    parameter int SHAMT = IMM_SHAMT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  imm_mode_t        in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    pipe_state_t      r_state;
    logic [OUT_W-1:0] r_out_data;
    logic [OUT_W-1:0] r_skid_data;

    logic [OUT_W-1:0] w_ext;
    logic             w_out_valid;
    logic             w_skid_valid;
    logic             w_accept;
    logic             w_drain;

    // Extension happens on the input side so the skid stores finished data
    // and the FULL->ONE transfer is a plain register copy.
    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHAMT (SHAMT)
    ) u_ext (
        .i_imm  (in_imm),
        .i_mode (in_mode),
        .o_data (w_ext)
    );

    assign w_out_valid  = r_state[0];
    assign w_skid_valid = r_state[1];

    assign in_ready  = !w_skid_valid;
    assign out_valid = w_out_valid;
    assign out_data  = r_out_data;

    assign w_accept = in_valid && in_ready;
    assign w_drain  = w_out_valid && out_ready;

    // Occupancy FSM and data registers; reset discards both entries at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_data  <= '0;
            r_skid_data <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_out_data <= w_ext;
                        r_state    <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_drain && w_accept) begin
                        r_out_data <= w_ext;
                    end else if (w_drain) begin
                        r_state <= ST_EMPTY;
                    end else if (w_accept) begin
                        r_skid_data <= w_ext;
                        r_state     <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the skid can move forward.
                    if (w_drain) begin
                        r_out_data <= r_skid_data;
                        r_state    <= ST_ONE;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    // An unknown mode on a presented immediate is an upstream bug.
    a_mode_known: assert property (@(posedge clk) disable iff (rst)
        in_valid |-> !$isunknown(in_mode));

endmodule
